// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the core store path, the TX byte FIFO and the UART serializer.
// slave = FIFO side, master = core/serializer side.
interface uart_tx_fifo_if #(
    parameter int PTR_W = 4
);
    logic             wr_i;
    logic [7:0]       wr_dat_i;
    logic             ovf_clr_i;
    logic             tx_busy_i;
    logic             tx_wr_o;
    logic [7:0]       tx_dat_o;
    logic             full_o;
    logic             empty_o;
    logic [PTR_W:0]   count_o;
    logic             ovf_o;

    modport slave (
        input  wr_i, wr_dat_i, ovf_clr_i, tx_busy_i,
        output tx_wr_o, tx_dat_o, full_o, empty_o, count_o, ovf_o
    );

    modport master (
        output wr_i, wr_dat_i, ovf_clr_i, tx_busy_i,
        input  tx_wr_o, tx_dat_o, full_o, empty_o, count_o, ovf_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer, drained one byte per strobe paced by tx_busy_i.
// Optional status read port enabled by defining UART_TXFIFO_STATUS_EN.
module uart_tx_fifo #(
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4,
    parameter int BUSY_TO = 4
`ifdef UART_TXFIFO_STATUS_EN
    , parameter logic [31:0] STATUS_ADDR = 32'hffffff04
`endif
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,
    uart_tx_fifo_if.slave         bus
`ifdef UART_TXFIFO_STATUS_EN
    , input  logic [31:0]         rd_addr_i
    , output logic [31:0]         rd_data_o
`endif
);
    localparam int             TMR_W     = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TO - 1);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

    state_e             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               tx_wr_q, tx_wr_d;
    logic [7:0]         tx_dat_q, tx_dat_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               full, empty, pop, push;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign pop   = (state_q == ISSUE);
    // A full FIFO still takes a byte when the ISSUE cycle frees a slot at the same edge.
    assign push  = bus.wr_i && (!full || pop);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        if (bus.wr_i && !push) ovf_d = 1'b1;
        else if (bus.ovf_clr_i) ovf_d = 1'b0;
    end

    // NOTE: storage has no reset; entries are only read after being written, so reset just clears the pointers.
    always_ff @(posedge sys_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_dat_i;
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q  <= IDLE;
            tx_wr_q  <= 1'b0;
            tx_dat_q <= 8'h00;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            tx_wr_q  <= tx_wr_d;
            tx_dat_q <= tx_dat_d;
            tmr_q    <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!empty && !bus.tx_busy_i) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy_i)         state_d = WAIT_DONE;
                else if (tmr_q == TMR_LAST) state_d = IDLE;
            end
            WAIT_DONE: if (!bus.tx_busy_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are registered against the next state so tx_wr_o is high exactly while in ISSUE.
    always_comb begin
        tx_wr_d  = (state_d == ISSUE);
        tx_dat_d = (state_d == ISSUE) ? mem_q[rd_ptr_q] : tx_dat_q;
        tmr_d    = (state_q == WAIT_BUSY) ? tmr_q + TMR_W'(1) : '0;
    end

    assign bus.tx_wr_o  = tx_wr_q;
    assign bus.tx_dat_o = tx_dat_q;
    assign bus.full_o   = full;
    assign bus.empty_o  = empty;
    assign bus.count_o  = count_q;
    assign bus.ovf_o    = ovf_q;

`ifdef UART_TXFIFO_STATUS_EN
    always_comb begin
        rd_data_o = 32'h0;
        if (rd_addr_i == STATUS_ADDR) begin
            rd_data_o[15]      = ovf_q;
            rd_data_o[14]      = full;
            rd_data_o[13]      = empty;
            rd_data_o[12]      = (state_q != IDLE);
            rd_data_o[PTR_W:0] = count_q;
        end
    end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed timing cases plus a randomized run
// scored against a queue model of the FIFO and a behavioural serializer busy model.
module tb_uart_tx_fifo;
  localparam int DEPTH   = 16;
  localparam int PTR_W   = 4;
  localparam int BUSY_TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.PTR_W(PTR_W)) bus ();
`ifdef UART_TXFIFO_STATUS_EN
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .BUSY_TO(BUSY_TO)) dut (
    .sys_clk_i  (clk),
    .sys_rstn_i (rst_n),
    .bus        (bus)
`ifdef UART_TXFIFO_STATUS_EN
    , .rd_addr_i (rd_addr)
    , .rd_data_o (rd_data)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit auto_busy = 1'b0;
  int busy_len = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];
  int strobe_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; outputs are sampled 1ns after the rising edge. The serializer model
  // goes busy for busy_len cycles after each strobe (busy_len=0: strobe ignored).
  task automatic step();
    logic was_strobe;
    was_strobe = bus.tx_wr_o;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_busy) begin
      if (was_strobe && busy_len > 0) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy_i = (busy_cnt > 0);
    end
  endtask

  task automatic do_reset();
    auto_busy = 1'b0;
    busy_cnt = 0;
    bus.wr_i = 1'b0;
    bus.wr_dat_i = 8'h00;
    bus.ovf_clr_i = 1'b0;
    bus.tx_busy_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.wr_i = 1'b1;
    bus.wr_dat_i = b;
    step();
    bus.wr_i = 1'b0;
  endtask

  // Releases busy, expects n strobes carrying exp_q in order, then no further strobe.
  task automatic drain(input int n, input int blen, input int budget);
    int got = 0;
    int extra = 0;
    auto_busy = 1'b1;
    busy_len = blen;
    busy_cnt = 0;
    bus.tx_busy_i = 1'b0;
    strobe_cyc.delete();
    while (got < n && budget > 0) begin
      if (bus.tx_wr_o) begin
        got++;
        strobe_cyc.push_back(cyc);
        if (exp_q.size() > 0) check("drain_data", {24'h0, bus.tx_dat_o}, {24'h0, exp_q.pop_front()});
        else check("drain_unexpected", {31'h0, bus.tx_wr_o}, 32'h0);
      end
      step();
      budget--;
    end
    check("drain_count", got, n);
    repeat (3 * (blen + BUSY_TO + 4)) begin
      if (bus.tx_wr_o) extra++;
      step();
    end
    check("drain_extra", extra, 0);
    auto_busy = 1'b0;
    bus.tx_busy_i = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_i = 1'b0;
    bus.wr_dat_i = 8'h00;
    bus.ovf_clr_i = 1'b0;
    bus.tx_busy_i = 1'b0;
`ifdef UART_TXFIFO_STATUS_EN
    rd_addr = 32'h0;
`endif
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", {27'h0, bus.count_o}, 32'd0);
    check("rst_empty", {31'h0, bus.empty_o}, 32'd1);
    check("rst_full", {31'h0, bus.full_o}, 32'd0);
    check("rst_ovf", {31'h0, bus.ovf_o}, 32'd0);
    check("rst_tx_wr", {31'h0, bus.tx_wr_o}, 32'd0);
    check("rst_tx_dat", {24'h0, bus.tx_dat_o}, 32'h00);
    do_reset();

    // Single byte latency: push at edge N, strobe in cycle N+2, empty again in N+3.
    push_byte(8'h41);
    check("single_n1_tx_wr", {31'h0, bus.tx_wr_o}, 32'd0);
    check("single_n1_count", {27'h0, bus.count_o}, 32'd1);
    step();
    check("single_n2_tx_wr", {31'h0, bus.tx_wr_o}, 32'd1);
    check("single_n2_tx_dat", {24'h0, bus.tx_dat_o}, 32'h41);
    check("single_n2_empty", {31'h0, bus.empty_o}, 32'd0);
    step();
    check("single_n3_tx_wr", {31'h0, bus.tx_wr_o}, 32'd0);
    check("single_n3_empty", {31'h0, bus.empty_o}, 32'd1);
    check("single_n3_tx_dat_held", {24'h0, bus.tx_dat_o}, 32'h41);
    repeat (8) step();

    // Fill to full with busy held, then overflow with the 17th byte.
    bus.tx_busy_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(i));
      if (i == 15) begin
        check("fill_full", {31'h0, bus.full_o}, 32'd1);
        check("fill_count16", {27'h0, bus.count_o}, 32'd16);
        check("fill_no_ovf_yet", {31'h0, bus.ovf_o}, 32'd0);
      end
    end
    check("ovf_set", {31'h0, bus.ovf_o}, 32'd1);
    check("ovf_count16", {27'h0, bus.count_o}, 32'd16);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    drain(16, 10, 2000);
    check("ovf_sticky", {31'h0, bus.ovf_o}, 32'd1);
    check("drained_empty", {31'h0, bus.empty_o}, 32'd1);
    bus.ovf_clr_i = 1'b1;
    step();
    bus.ovf_clr_i = 1'b0;
    check("ovf_cleared", {31'h0, bus.ovf_o}, 32'd0);

    // Full FIFO plus push in the ISSUE cycle is accepted.
    bus.tx_busy_i = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'h50 + 8'(i));
    check("full2_full", {31'h0, bus.full_o}, 32'd1);
    bus.tx_busy_i = 1'b0;
    for (int i = 0; i < 4 && !bus.tx_wr_o; i++) step();
    check("full2_issue_seen", {31'h0, bus.tx_wr_o}, 32'd1);
    check("full2_issue_dat", {24'h0, bus.tx_dat_o}, 32'h50);
    push_byte(8'hAA);
    check("full2_count", {27'h0, bus.count_o}, 32'd16);
    check("full2_ovf", {31'h0, bus.ovf_o}, 32'd0);
    for (int i = 1; i < 16; i++) exp_q.push_back(8'h50 + 8'(i));
    exp_q.push_back(8'hAA);
    drain(16, 10, 3000);

    // Serializer never raises busy: strobes spaced by the busy timeout.
    bus.tx_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_byte(8'hC0 + 8'(i));
      exp_q.push_back(8'hC0 + 8'(i));
    end
    drain(3, 0, 200);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check("timeout_gap", strobe_cyc[i] - strobe_cyc[i-1], BUSY_TO + 2);

`ifdef UART_TXFIFO_STATUS_EN
    bus.tx_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(8'h70 + 8'(i));
    rd_addr = 32'hffffff04;
    #1;
    check("status_count", {27'h0, rd_data[4:0]}, 32'd3);
    check("status_empty_bit", {31'h0, rd_data[13]}, 32'd0);
    check("status_upper", {16'h0, rd_data[31:16]}, 32'd0);
    rd_addr = 32'hffffff00;
    #1;
    check("status_other_addr", rd_data, 32'd0);
    do_reset();
`endif

    // Reset during the ISSUE cycle drops the strobe immediately.
    push_byte(8'h99);
    for (int i = 0; i < 4 && !bus.tx_wr_o; i++) step();
    check("rst_issue_seen", {31'h0, bus.tx_wr_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_issue_tx_wr", {31'h0, bus.tx_wr_o}, 32'd0);
    check("rst_issue_tx_dat", {24'h0, bus.tx_dat_o}, 32'h00);
    do_reset();

    // Reset during WAIT_DONE with bytes queued.
    bus.tx_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    auto_busy = 1'b1;
    busy_len = 20;
    busy_cnt = 0;
    bus.tx_busy_i = 1'b0;
    for (int i = 0; i < 4 && !bus.tx_wr_o; i++) step();
    check("rst_drain_issue_seen", {31'h0, bus.tx_wr_o}, 32'd1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_drain_tx_wr", {31'h0, bus.tx_wr_o}, 32'd0);
    check("rst_drain_count", {27'h0, bus.count_o}, 32'd0);
    do_reset();
    begin
      int extra = 0;
      repeat (30) begin
        if (bus.tx_wr_o) extra++;
        step();
      end
      check("rst_drain_no_strobe", extra, 0);
      check("rst_drain_count_after", {27'h0, bus.count_o}, 32'd0);
    end

    // Randomized run against a queue model of the FIFO.
    begin
      bit mdl_ovf = 1'b0;
      bit busy_last = 1'b0;
      auto_busy = 1'b1;
      busy_cnt = 0;
      bus.tx_busy_i = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        bit strobe, wr, clr, full_before;
        logic [7:0] dat;
        check("rnd_count", {27'h0, bus.count_o}, exp_q.size());
        check("rnd_empty", {31'h0, bus.empty_o}, {31'h0, exp_q.size() == 0});
        check("rnd_full", {31'h0, bus.full_o}, {31'h0, exp_q.size() == DEPTH});
        check("rnd_ovf", {31'h0, bus.ovf_o}, {31'h0, mdl_ovf});
        strobe = bus.tx_wr_o;
        if (strobe) begin
          check("rnd_strobe_nonempty", {31'h0, exp_q.size() > 0}, 32'd1);
          check("rnd_busy_gate", {31'h0, busy_last}, 32'd0);
          if (exp_q.size() > 0) check("rnd_data", {24'h0, bus.tx_dat_o}, {24'h0, exp_q[0]});
          busy_len = int'($urandom_range(0, 10));
        end
        wr = ($urandom_range(0, 99) < ((c < 700) ? 60 : 12));
        clr = ($urandom_range(0, 99) < 3);
        dat = 8'($urandom);
        bus.wr_i = wr;
        bus.wr_dat_i = dat;
        bus.ovf_clr_i = clr;
        busy_last = bus.tx_busy_i;
        step();
        full_before = (exp_q.size() == DEPTH);
        if (strobe && exp_q.size() > 0) void'(exp_q.pop_front());
        if (wr && (!full_before || strobe)) exp_q.push_back(dat);
        if (wr && full_before && !strobe) mdl_ovf = 1'b1;
        else if (clr) mdl_ovf = 1'b0;
      end
      bus.wr_i = 1'b0;
      bus.ovf_clr_i = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
